// File: rtl/jesd204_fec_mb_sequencer.sv
// Multiblock sequencer and status controller for a JESD204C 64B/66B FEC encoder/decoder pair.
// Tracks beat position, drives encoder/decoder strobes and turns decoder error flags into lock status.
module jesd204_fec_mb_sequencer #(
  parameter int BEATS_PER_MB = 32,
  parameter int FEC_DELAY    = 27,
  parameter int CNT_WIDTH    = 16,
  parameter int UNTRAP_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_enable,
  input  logic                 cfg_clear,
  input  logic                 data_valid,
  input  logic                 mb_start,
  input  logic [25:0]          enc_fec,
  input  logic                 dec_trapped_error,
  input  logic                 dec_untrapped_error,
  output logic                 enc_shift_en,
  output logic                 enc_eomb,
  output logic                 dec_eomb,
  output logic                 dec_fec_in_valid,
  output logic [25:0]          fec_tx,
  output logic                 fec_tx_valid,
  output logic                 align_err,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] trapped_cnt,
  output logic [CNT_WIDTH-1:0] untrapped_cnt,
  output logic                 lost_lock
);

  localparam int BEAT_W   = (BEATS_PER_MB > 2) ? $clog2(BEATS_PER_MB) : 1;
  localparam int CONSEC_W = $clog2(UNTRAP_LIMIT + 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS_PER_MB - 1);
  localparam logic [CONSEC_W-1:0] LIMIT_V   = CONSEC_W'(UNTRAP_LIMIT);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_WAIT_MB  = 2'd1,
    ST_RUN      = 2'd2,
    ST_LOST     = 2'd3
  } state_t;

  state_t                state_q;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [FEC_DELAY-1:0]  delay_line;
  logic [FEC_DELAY-1:0]  delay_next;
  logic [CONSEC_W-1:0]   consec;
  logic [CONSEC_W-1:0]   consec_next;
  logic                  mb_untrapped;
  logic                  running;
  logic                  misalign;
  logic                  count_en;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    running          = (state_q == ST_RUN) || (state_q == ST_LOST);
    misalign         = running && data_valid && mb_start && (beat_cnt != '0);
    enc_shift_en     = data_valid && running;
    enc_eomb         = enc_shift_en && (beat_cnt == LAST_BEAT) && !misalign;
    dec_eomb         = enc_eomb;
    delay_next       = FEC_DELAY'({delay_line, enc_eomb});
    dec_fec_in_valid = delay_line[FEC_DELAY-1];
    count_en         = cfg_enable && (state_q != ST_DISABLED);
    consec_next      = consec;
    // An error arriving in the evaluation cycle itself still counts for the closing multiblock.
    if (dec_fec_in_valid) begin
      if (mb_untrapped || dec_untrapped_error) begin
        consec_next = (consec == LIMIT_V) ? consec : consec + CONSEC_W'(1);
      end else begin
        consec_next = '0;
      end
    end
  end

  assign state     = state_q;
  assign lost_lock = (state_q == ST_LOST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_DISABLED;
      beat_cnt      <= '0;
      delay_line    <= '0;
      consec        <= '0;
      mb_untrapped  <= 1'b0;
      fec_tx        <= '0;
      fec_tx_valid  <= 1'b0;
      align_err     <= 1'b0;
      trapped_cnt   <= '0;
      untrapped_cnt <= '0;
    end else begin
      fec_tx_valid <= enc_eomb;
      align_err    <= misalign;
      if (enc_eomb) begin
        fec_tx <= enc_fec;
      end

      if (!cfg_enable) begin
        state_q      <= ST_DISABLED;
        beat_cnt     <= '0;
        delay_line   <= '0;
        consec       <= '0;
        mb_untrapped <= 1'b0;
      end else begin
        // Realignment drops any parity strobe still in flight for the abandoned multiblock.
        delay_line <= misalign ? '0 : delay_next;

        unique case (state_q)
          ST_DISABLED: state_q <= ST_WAIT_MB;
          ST_WAIT_MB: begin
            if (data_valid && mb_start) begin
              state_q  <= ST_RUN;
              beat_cnt <= BEAT_W'(1);
            end
          end
          ST_RUN, ST_LOST: begin
            if (misalign) begin
              beat_cnt <= BEAT_W'(1);
            end else if (data_valid) begin
              beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
            end
            if ((state_q == ST_RUN) && (consec_next == LIMIT_V)) begin
              state_q <= ST_LOST;
            end
          end
          default: state_q <= ST_DISABLED;
        endcase

        if (dec_fec_in_valid) begin
          mb_untrapped <= 1'b0;
        end else if (dec_untrapped_error) begin
          mb_untrapped <= 1'b1;
        end
        consec <= consec_next;

        if (cfg_clear) begin
          consec       <= '0;
          mb_untrapped <= 1'b0;
          if (running) begin
            state_q <= ST_RUN;
          end
        end
      end

      if (cfg_clear) begin
        trapped_cnt   <= '0;
        untrapped_cnt <= '0;
      end else if (count_en) begin
        if (dec_trapped_error && !(&trapped_cnt)) begin
          trapped_cnt <= trapped_cnt + CNT_WIDTH'(1);
        end
        if (dec_untrapped_error && !(&untrapped_cnt)) begin
          untrapped_cnt <= untrapped_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
